tc_sram_initiator: RTL and testbench

//  Requester-side adapter for one port of the functional SRAM macro. Takes a valid/ready

---
 rtl/tc_sram_initiator.sv | 131 +++++++++++++
 tb/tb_tc_sram_initiator.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tc_sram_initiator.sv
// Requester-side adapter for one SRAM port: issues valid/ready requests and buffers fixed-latency
// read data in a credit-reserved response FIFO. Optional macro TC_SRAM_INIT_WRITE_ACK_EN adds write acks.
module tc_sram_initiator #(
   parameter int unsigned NumWords  = 32,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned ByteWidth = 8,
   parameter int unsigned Latency   = 1,
   parameter int unsigned RspDepth  = 4,
   localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
   localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic                 req_we_i,
   input  logic [AddrWidth-1:0] req_addr_i,
   input  logic [DataWidth-1:0] req_wdata_i,
   input  logic [BeWidth-1:0]   req_be_i,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output logic [DataWidth-1:0] rsp_rdata_o,
   output logic                 rsp_we_o,
   output logic                 sram_req_o,
   output logic                 sram_we_o,
   output logic [AddrWidth-1:0] sram_addr_o,
   output logic [DataWidth-1:0] sram_wdata_o,
   output logic [BeWidth-1:0]   sram_be_o,
   input  logic [DataWidth-1:0] sram_rdata_i
);

`ifdef TC_SRAM_INIT_WRITE_ACK_EN
   localparam logic WriteAck = 1'b1;
`else
   localparam logic WriteAck = 1'b0;
`endif

   localparam int unsigned PipeW = (Latency > 0) ? Latency : 1;
   localparam int unsigned Top   = PipeW - 1;
   localparam int unsigned PtrW  = (RspDepth > 1) ? $clog2(RspDepth) : 1;
   localparam int unsigned CntW  = $clog2(RspDepth + Latency + 1) + 1;

   logic [PipeW-1:0]     pipe_vld_q, pipe_vld_d, pipe_ack_q, pipe_ack_d;
   logic [CntW-1:0]      occ_q, occ_d, infl;
   logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DataWidth-1:0] mem_data_q [RspDepth];
   logic                 mem_ack_q  [RspDepth];
   logic                 issue, issue_ack, issue_track, push, push_ack, pop;

   // Credit uses registered terms only, so a pop frees a slot from the next cycle on.
   assign req_ready_o  = rst_ni & ((occ_q + infl) < CntW'(RspDepth));
   assign issue        = req_valid_i & req_ready_o;
   assign sram_req_o   = issue;
   assign sram_we_o    = issue & req_we_i;
   assign sram_addr_o  = req_addr_i;
   assign sram_wdata_o = req_wdata_i;
   assign sram_be_o    = issue ? req_be_i : '0;

   assign issue_ack   = WriteAck & issue & req_we_i;
   assign issue_track = (issue & ~req_we_i) | issue_ack;

   assign rsp_valid_o = rst_ni & (occ_q != '0);
   assign rsp_rdata_o = mem_data_q[rd_ptr_q];
   assign rsp_we_o    = WriteAck & mem_ack_q[rd_ptr_q];
   assign pop         = rsp_valid_o & rsp_ready_i;

   always_comb begin
      infl = '0;
      for (int i = 0; i < PipeW; i++) begin
         infl = infl + CntW'(pipe_vld_q[i]);
      end
   end

   // Entries enter at the top of the pipe and reach bit 0 in the cycle the SRAM returns data.
   always_comb begin
      pipe_vld_d = pipe_vld_q >> 1;
      pipe_ack_d = pipe_ack_q >> 1;
      push       = 1'b0;
      push_ack   = 1'b0;
      if (Latency == 0) begin
         pipe_vld_d = '0;
         pipe_ack_d = '0;
         push       = issue_track;
         push_ack   = issue_ack;
      end else begin
         pipe_vld_d[Top] = issue_track;
         pipe_ack_d[Top] = issue_ack;
         push            = pipe_vld_q[0];
         push_ack        = pipe_ack_q[0];
      end
   end

   always_comb begin
      occ_d    = occ_q + CntW'(push) - CntW'(pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) wr_ptr_d = (wr_ptr_q == PtrW'(RspDepth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = (rd_ptr_q == PtrW'(RspDepth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         pipe_vld_q <= '0;
         pipe_ack_q <= '0;
         occ_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         pipe_vld_q <= pipe_vld_d;
         pipe_ack_q <= pipe_ack_d;
         occ_q      <= occ_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_data_q[wr_ptr_q] <= push_ack ? '0 : sram_rdata_i;
         mem_ack_q[wr_ptr_q]  <= push_ack;
      end
   end

`ifndef SYNTHESIS
   a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      push |-> (occ_q < CntW'(RspDepth)));
   a_credit_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (occ_q + infl) <= CntW'(RspDepth));
`endif

endmodule

// File: tb/tb_tc_sram_initiator.sv
// Self-checking bench for tc_sram_initiator: SRAM macro model plus a transaction-level
// reference (issued-minus-popped credit, expected-response queue with visibility cycle).
module tb_tc_sram_initiator;
   localparam int NW = 32, DW = 32, LAT = 1, DEPTH = 4, AW = 5, BEW = 4;
`ifdef TC_SRAM_INIT_WRITE_ACK_EN
   localparam bit WACK = 1'b1;
`else
   localparam bit WACK = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n, req_valid, req_we, rsp_ready;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic [BEW-1:0] req_be;
   logic          req_ready, rsp_valid, rsp_we, sram_req, sram_we;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] sram_wdata, rsp_rdata, sram_rdata;
   logic [BEW-1:0] sram_be;

   tc_sram_initiator #(.NumWords(NW), .DataWidth(DW), .ByteWidth(8), .Latency(LAT), .RspDepth(DEPTH)) dut (
      .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata), .rsp_we_o(rsp_we),
      .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
      .sram_wdata_o(sram_wdata), .sram_be_o(sram_be), .sram_rdata_i(sram_rdata));

   // SRAM macro: byte-enabled writes, reads returned LAT cycles later
   logic [DW-1:0] sram_mem [NW];
   logic [DW-1:0] sram_pipe [LAT];
   logic [DW-1:0] sram_tmp;
   always @(posedge clk) begin
      for (int i = 0; i < LAT - 1; i++) sram_pipe[i] <= sram_pipe[i+1];
      sram_pipe[LAT-1] <= 32'hBAD0BAD0;
      if (sram_req) begin
         if (sram_we) begin
            sram_tmp = sram_mem[sram_addr];
            for (int b = 0; b < BEW; b++) if (sram_be[b]) sram_tmp[b*8 +: 8] = sram_wdata[b*8 +: 8];
            sram_mem[sram_addr] <= sram_tmp;
         end else begin
            sram_pipe[LAT-1] <= sram_mem[sram_addr];
         end
      end
   end
   assign sram_rdata = sram_pipe[0];

   typedef struct { logic [DW-1:0] data; logic we; int avail; } rsp_t;
   rsp_t          exp_q[$];
   logic [DW-1:0] ref_mem [NW];
   int            cyc = 0, passed = 0, total = 0;
   logic          obs_ready, obs_valid, obs_we, obs_sreq;
   logic [DW-1:0] obs_rdata;

   task automatic drive(input logic v, input logic we, input int addr, input logic [DW-1:0] d,
                        input logic [BEW-1:0] be);
      req_valid = v; req_we = we; req_addr = AW'(addr); req_wdata = d; req_be = be;
   endtask

   // One clock: scoreboard the cycle against the reference, then advance the reference.
   task automatic step();
      logic exp_ready, exp_valid, issue;
      rsp_t e;
      @(negedge clk);
      obs_ready = req_ready; obs_valid = rsp_valid; obs_rdata = rsp_rdata;
      obs_we = rsp_we; obs_sreq = sram_req;
      exp_ready = rst_n && (exp_q.size() < DEPTH);
      exp_valid = rst_n && (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
      total++;
      if (obs_ready !== exp_ready) $display("FAIL ready cyc=%0d got=%b want=%b", cyc, obs_ready, exp_ready);
      else passed++;
      total++;
      if (obs_sreq !== (req_valid & exp_ready))
         $display("FAIL sram_req cyc=%0d got=%b want=%b", cyc, obs_sreq, req_valid & exp_ready);
      else passed++;
      total++;
      if (obs_valid !== exp_valid) $display("FAIL rsp_valid cyc=%0d got=%b want=%b", cyc, obs_valid, exp_valid);
      else passed++;
      if (exp_valid) begin
         total++;
         if (obs_rdata !== exp_q[0].data || obs_we !== exp_q[0].we)
            $display("FAIL rsp_data cyc=%0d got=%h/%b want=%h/%b", cyc, obs_rdata, obs_we,
                     exp_q[0].data, exp_q[0].we);
         else passed++;
      end
      issue = req_valid && exp_ready;
      @(posedge clk);
      if (!rst_n) exp_q.delete();
      else begin
         if (exp_valid && rsp_ready) void'(exp_q.pop_front());
         if (issue) begin
            if (req_we) begin
               for (int b = 0; b < BEW; b++) if (req_be[b]) ref_mem[req_addr][b*8 +: 8] = req_wdata[b*8 +: 8];
               if (WACK) begin e.data = '0; e.we = 1'b1; e.avail = cyc + LAT + 1; exp_q.push_back(e); end
            end else begin
               e.data = ref_mem[req_addr]; e.we = 1'b0; e.avail = cyc + LAT + 1; exp_q.push_back(e);
            end
         end
      end
      cyc++;
      #1;
   endtask

   task automatic idle(input int n);
      drive(0, 0, 0, '0, '0);
      rsp_ready = 1'b1;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; rsp_ready = 1'b1;
      drive(1, 0, 3, '0, '0);
      for (int i = 0; i < 3; i++) step();
      total++;
      if (obs_ready !== 1'b0 || obs_sreq !== 1'b0 || obs_valid !== 1'b0)
         $display("FAIL reset_outputs got rdy=%b req=%b vld=%b want 0/0/0", obs_ready, obs_sreq, obs_valid);
      else passed++;
      rst_n = 1'b1;
      drive(0, 0, 0, '0, '0);
      step();
      total++;
      if (obs_ready !== 1'b1) $display("FAIL ready_after_reset got=%b want=1", obs_ready);
      else passed++;
   endtask

   task automatic test_fill();
      rsp_ready = 1'b1;
      for (int a = 0; a < NW; a++) begin
         drive(1, 1, a, DW'($urandom), '1);
         step();
      end
      idle(6);
   endtask

   task automatic test_write_read();
      drive(1, 1, 5, 32'hDEADBEEF, 4'hF); step();
      idle(6);
      drive(1, 0, 5, '0, '0); step();
      drive(0, 0, 0, '0, '0); step();
      total++;
      if (obs_valid !== 1'b0) $display("FAIL wr_rd_early got=%b want=0", obs_valid);
      else passed++;
      step();
      total++;
      if (obs_valid !== 1'b1 || obs_rdata !== 32'hDEADBEEF)
         $display("FAIL wr_rd_data got=%b/%h want=1/deadbeef", obs_valid, obs_rdata);
      else passed++;
      idle(4);
   endtask

   task automatic test_back_to_back();
      int issued = 0, got = 0;
      for (int a = 0; a < 8; a++) begin drive(1, 1, a, DW'(32'h100 + a), '1); step(); end
      idle(6);
      for (int a = 0; a < 12; a++) begin
         if (a < 8) drive(1, 0, a, '0, '0); else drive(0, 0, 0, '0, '0);
         step();
         if (obs_sreq) issued++;
         if (obs_valid) begin
            total++;
            if (obs_rdata !== DW'(32'h100 + got)) $display("FAIL b2b_order got=%h want=%h", obs_rdata, 32'h100 + got);
            else passed++;
            got++;
         end
      end
      total++;
      if (issued !== 8 || got !== 8) $display("FAIL b2b_count got=%0d/%0d want=8/8", issued, got);
      else passed++;
   endtask

   task automatic test_backpressure();
      int n = 0, got = 0;
      for (int a = 0; a < 4; a++) begin drive(1, 1, a, DW'(a), '1); step(); end
      idle(6);
      rsp_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         drive(1, 0, n % 4, '0, '0);
         step();
         if (obs_sreq) n++;
      end
      total++;
      if (n !== 4 || obs_ready !== 1'b0) $display("FAIL bp_accept got=%0d rdy=%b want=4 rdy=0", n, obs_ready);
      else passed++;
      drive(0, 0, 0, '0, '0);
      rsp_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         if (obs_valid) begin
            total++;
            if (obs_rdata !== DW'(got)) $display("FAIL bp_drain got=%h want=%h", obs_rdata, got);
            else passed++;
            got++;
         end
      end
      total++;
      if (got !== 4) $display("FAIL bp_drain_count got=%0d want=4", got);
      else passed++;
   endtask

   task automatic test_partial_write();
      logic seen = 1'b0;
      drive(1, 1, 9, 32'h11223344, 4'hF); step();
      drive(1, 1, 9, 32'h0000AB00, 4'b0010); step();
      idle(6);
      drive(1, 0, 9, '0, '0); step();
      drive(0, 0, 0, '0, '0);
      for (int i = 0; i < 6; i++) begin
         step();
         if (obs_valid && !seen) begin
            seen = 1'b1;
            total++;
            if (obs_rdata !== 32'h1122AB44) $display("FAIL partial_write got=%h want=1122ab44", obs_rdata);
            else passed++;
         end
      end
      total++;
      if (!seen) $display("FAIL partial_write_timeout got=none want=1 response");
      else passed++;
   endtask

`ifdef TC_SRAM_INIT_WRITE_ACK_EN
   task automatic test_write_ack();
      int got = 0;
      logic [DW-1:0] d [2];
      logic          w [2];
      drive(1, 1, 12, 32'hCAFE0012, '1); step();
      drive(1, 0, 12, '0, '0); step();
      drive(0, 0, 0, '0, '0);
      for (int i = 0; i < 8; i++) begin
         step();
         if (obs_valid && got < 2) begin d[got] = obs_rdata; w[got] = obs_we; got++; end
      end
      total++;
      if (got !== 2 || w[0] !== 1'b1 || d[0] !== '0 || w[1] !== 1'b0 || d[1] !== 32'hCAFE0012)
         $display("FAIL write_ack got n=%0d %b/%h %b/%h want 2 1/0 0/cafe0012", got, w[0], d[0], w[1], d[1]);
      else passed++;
   endtask
`endif

   task automatic test_reset_inflight();
      int seen = 0;
      rsp_ready = 1'b0;
      drive(1, 0, 1, '0, '0); step();
      drive(1, 0, 2, '0, '0); step();
      drive(0, 0, 0, '0, '0);
      rst_n = 1'b0; step();
      rst_n = 1'b1; rsp_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin step(); if (obs_valid) seen++; end
      total++;
      if (seen !== 0) $display("FAIL reset_inflight got=%0d responses want=0", seen);
      else passed++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive(($urandom % 4) != 0, $urandom % 2, $urandom % NW, DW'($urandom), BEW'($urandom));
         rsp_ready = (i % 50 < 10) ? 1'b0 : (($urandom % 3) != 0);
         step();
      end
      idle(10);
      total++;
      if (obs_valid !== 1'b0 || obs_ready !== 1'b1)
         $display("FAIL random_drain got vld=%b rdy=%b want 0/1", obs_valid, obs_ready);
      else passed++;
   endtask

   initial begin
      drive(0, 0, 0, '0, '0);
      rst_n = 1'b0; rsp_ready = 1'b1;
      test_reset();
      test_fill();
      test_write_read();
      test_back_to_back();
      test_backpressure();
      test_partial_write();
`ifdef TC_SRAM_INIT_WRITE_ACK_EN
      test_write_ack();
`endif
      test_reset_inflight();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
